// File: rtl/vip_pkg.sv
// Shared constants for the VIP binary processing chain.
package vip_pkg;

    localparam int MORPH_ERODE  = 0;
    localparam int MORPH_DILATE = 1;

    // depth of the vsync/href/clken delay line that matches the pixel pipeline
    localparam int VIP_SYNC_LAT = 3;

endpackage

// File: rtl/vip_bit_line_buf.sv
// One line of 1-bit pixels: single address, read-before-write, registered read.
module vip_bit_line_buf #(
    parameter int DEPTH = 640,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];
    logic rdata_q;

    // storage and read register carry no reset; stale data is masked downstream
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[addr_i];
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vip_bin_morph_3x3.sv
// 3x3 binary erosion/dilation on a vsync/href/clken pixel stream, two line buffers,
// result and sync signals both delayed by VIP_SYNC_LAT clocks.
module vip_bin_morph_3x3
    import vip_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int MODE      = MORPH_ERODE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_bit
);

    localparam int              CW      = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int              RW      = $clog2(IMG_VDISP + 1);
    localparam logic [CW-1:0]   COL_MAX = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0]   ROW_MAX = RW'(IMG_VDISP);
    localparam logic            IDENT   = (MODE == MORPH_ERODE);

    logic          vsync_q, href_q;
    logic          vsync_rise, href_fall, accept, we0;
    logic [CW-1:0] col_q, col_d, col_eff;
    logic          col_full_q, col_full_d, full_eff;
    logic [RW-1:0] row_q, row_d, row_eff;

    assign accept     = per_frame_href & per_frame_clken;
    assign vsync_rise = per_frame_vsync & ~vsync_q;
    assign href_fall  = ~per_frame_href & href_q;

    // a frame start takes effect in the same clock, so the first pixel lands at row 0 / col 0
    assign col_eff  = vsync_rise ? '0   : col_q;
    assign full_eff = vsync_rise ? 1'b0 : col_full_q;
    assign row_eff  = vsync_rise ? '0   : row_q;
    assign we0      = accept & ~full_eff;

    always_comb begin
        col_d      = col_eff;
        col_full_d = full_eff;
        row_d      = row_eff;
        if (href_fall) begin
            col_d      = '0;
            col_full_d = 1'b0;
            if (!vsync_rise && row_q != ROW_MAX) begin
                row_d = row_q + 1'b1;
            end
        end else if (we0) begin
            if (col_eff == COL_MAX) begin
                col_full_d = 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            col_q      <= '0;
            col_full_q <= 1'b0;
            row_q      <= '0;
        end else begin
            vsync_q    <= per_frame_vsync;
            href_q     <= per_frame_href;
            col_q      <= col_d;
            col_full_q <= col_full_d;
            row_q      <= row_d;
        end
    end

    logic          rd0, rd1;
    logic          pix1_q, ok1_1_q, ok2_1_q, first1_q, we1_q;
    logic [CW-1:0] addr1_q;
    logic          pix2_q, rd0_2_q, ok1_2_q, ok2_2_q, first2_q;

    vip_bit_line_buf #(.DEPTH(IMG_HDISP), .AW(CW)) u_line0 (
        .clk     (clk),
        .we_i    (we0),
        .addr_i  (col_eff),
        .wdata_i (per_img_bit),
        .rdata_o (rd0)
    );

    // line1 runs one clock behind line0 so the displaced line0 bit is available as write data
    vip_bit_line_buf #(.DEPTH(IMG_HDISP), .AW(CW)) u_line1 (
        .clk     (clk),
        .we_i    (we1_q),
        .addr_i  (addr1_q),
        .wdata_i (rd0),
        .rdata_o (rd1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix1_q   <= 1'b0;
            ok1_1_q  <= 1'b0;
            ok2_1_q  <= 1'b0;
            first1_q <= 1'b0;
            we1_q    <= 1'b0;
            addr1_q  <= '0;
            pix2_q   <= 1'b0;
            rd0_2_q  <= 1'b0;
            ok1_2_q  <= 1'b0;
            ok2_2_q  <= 1'b0;
            first2_q <= 1'b0;
        end else begin
            pix1_q   <= per_img_bit;
            ok1_1_q  <= (row_eff != '0);
            ok2_1_q  <= (row_eff > RW'(1));
            first1_q <= (col_eff == '0) & ~full_eff;
            we1_q    <= we0;
            addr1_q  <= col_eff;
            pix2_q   <= pix1_q;
            rd0_2_q  <= rd0;
            ok1_2_q  <= ok1_1_q;
            ok2_2_q  <= ok2_1_q;
            first2_q <= first1_q;
        end
    end

    logic [VIP_SYNC_LAT-1:0] vs_dly_q, hr_dly_q, ck_dly_q;
    logic                    acc2;
    logic [2:0]              win2_q, win1_q, win0_q;
    logic [2:0]              win2_d, win1_d, win0_d;
    logic                    res_d, bit_q;

    assign acc2 = hr_dly_q[VIP_SYNC_LAT-2] & ck_dly_q[VIP_SYNC_LAT-2];

    // window columns hold {row y-2, row y-1, row y}; win0 is column x
    always_comb begin
        win0_d = {ok2_2_q ? rd1 : IDENT, ok1_2_q ? rd0_2_q : IDENT, pix2_q};
        win1_d = win0_q;
        win2_d = win1_q;
        if (first2_q) begin
            win1_d = {3{IDENT}};
            win2_d = {3{IDENT}};
        end
        if (MODE == MORPH_DILATE) begin
            res_d = |{win2_d, win1_d, win0_d};
        end else begin
            res_d = &{win2_d, win1_d, win0_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_dly_q <= '0;
            hr_dly_q <= '0;
            ck_dly_q <= '0;
            win0_q   <= '0;
            win1_q   <= '0;
            win2_q   <= '0;
            bit_q    <= 1'b0;
        end else begin
            vs_dly_q <= {vs_dly_q[VIP_SYNC_LAT-2:0], per_frame_vsync};
            hr_dly_q <= {hr_dly_q[VIP_SYNC_LAT-2:0], per_frame_href};
            ck_dly_q <= {ck_dly_q[VIP_SYNC_LAT-2:0], per_frame_clken};
            if (acc2) begin
                win0_q <= win0_d;
                win1_q <= win1_d;
                win2_q <= win2_d;
                bit_q  <= res_d;
            end
        end
    end

    assign post_frame_vsync = vs_dly_q[VIP_SYNC_LAT-1];
    assign post_frame_href  = hr_dly_q[VIP_SYNC_LAT-1];
    assign post_frame_clken = ck_dly_q[VIP_SYNC_LAT-1];
    assign post_img_bit     = bit_q;

endmodule
